// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the ahb_master_bridge FSM state type.
// Contents: HTRANS codes, HSIZE codes, HBURST/HPROT constants, bridge state enum
// and a helper that maps the core's 2-bit size field to an effective AHB size.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StDone
  } bridge_state_e;

  // Size code 11 has no sub-word meaning on a 32-bit bus; treat it as a word.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    return (size == 2'b11) ? HSIZE_WORD[1:0] : size;
  endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// ahb_lane_steer: combinational byte-lane steering for a 32-bit AHB master.
// Request side: aligns the address to the access size and replicates write data
// across the lanes. Response side: extracts the addressed byte/halfword from the
// read bus, right-justified and zero-extended.
// Ports:
//   req_size, req_addr, req_wdata  in   core-side size, address, write data
//   aligned_addr, lane_wdata       out  AHB address and lane-replicated data
//   rsp_size, rsp_addr_lo          in   size and low address bits of the transfer
//   rsp_rdata                      in   raw HRDATA
//   rsp_data                       out  extracted, zero-extended read data
module ahb_lane_steer
  import ahb_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] aligned_addr,
  output logic [31:0] lane_wdata,
  input  logic [1:0]  rsp_size,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_data
);

  always_comb begin
    aligned_addr = req_addr;
    lane_wdata   = req_wdata;
    case (eff_size(req_size))
      2'b00: begin
        aligned_addr = req_addr;
        lane_wdata   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        aligned_addr = {req_addr[31:1], 1'b0};
        lane_wdata   = {2{req_wdata[15:0]}};
      end
      default: begin
        aligned_addr = {req_addr[31:2], 2'b00};
        lane_wdata   = req_wdata;
      end
    endcase
  end

  always_comb begin
    rsp_data = rsp_rdata;
    case (eff_size(rsp_size))
      2'b00: begin
        unique case (rsp_addr_lo)
          2'd0:    rsp_data = {24'h0, rsp_rdata[7:0]};
          2'd1:    rsp_data = {24'h0, rsp_rdata[15:8]};
          2'd2:    rsp_data = {24'h0, rsp_rdata[23:16]};
          default: rsp_data = {24'h0, rsp_rdata[31:24]};
        endcase
      end
      2'b01: begin
        rsp_data = rsp_addr_lo[1] ? {16'h0, rsp_rdata[31:16]} : {16'h0, rsp_rdata[15:0]};
      end
      default: rsp_data = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/ahb_master_bridge.sv
// ahb_master_bridge: converts the core's single-transfer request port into
// AHB-Lite master signalling, one outstanding transfer at a time.
// Optional feature macro: AHB_BRIDGE_ERR_EN (adds ahb_err, zeroes read data on
// ERROR responses). Without it, ERROR responses complete like OKAY.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ahb_en/ahb_wr_en/ahb_addr/ahb_wr_data/ahb_data_size   core request
//   ahb_rd_data/ahb_rd_vld/ahb_busy (/ahb_err)            core response
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA         AHB master outputs
//   HRDATA/HREADY/HRESP                                   AHB slave response
module ahb_master_bridge
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ahb_en,
  input  logic        ahb_wr_en,
  input  logic [31:0] ahb_addr,
  input  logic [31:0] ahb_wr_data,
  input  logic [1:0]  ahb_data_size,
  output logic [31:0] ahb_rd_data,
  output logic        ahb_rd_vld,
  output logic        ahb_busy,
`ifdef AHB_BRIDGE_ERR_EN
  output logic        ahb_err,
`endif
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  bridge_state_e state_q, state_d;
  logic [31:0]   haddr_q, haddr_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_vld_q, rd_vld_d;
  logic          busy_q, busy_d;

  logic [31:0]   aligned_addr;
  logic [31:0]   lane_wdata;
  logic [31:0]   rsp_data;

`ifdef AHB_BRIDGE_ERR_EN
  logic          err_q, err_d;
  assign ahb_err = err_q;
`else
  logic          unused_hresp;
  assign unused_hresp = HRESP;
`endif

  // Read extraction uses the registered HADDR/HSIZE: alignment never touches
  // the address bits that select the lane for the given size.
  ahb_lane_steer u_lane_steer (
    .req_size     (ahb_data_size),
    .req_addr     (ahb_addr),
    .req_wdata    (ahb_wr_data),
    .aligned_addr (aligned_addr),
    .lane_wdata   (lane_wdata),
    .rsp_size     (hsize_q[1:0]),
    .rsp_addr_lo  (haddr_q[1:0]),
    .rsp_rdata    (HRDATA),
    .rsp_data     (rsp_data)
  );

  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    htrans_d  = HTRANS_IDLE;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    hwdata_d  = hwdata_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    busy_d    = busy_q;
`ifdef AHB_BRIDGE_ERR_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (ahb_en) begin
          state_d  = StAddr;
          haddr_d  = aligned_addr;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = ahb_wr_en;
          hsize_d  = {1'b0, eff_size(ahb_data_size)};
          hwdata_d = lane_wdata;
          busy_d   = 1'b1;
        end
      end
      StAddr: begin
        htrans_d = HTRANS_NONSEQ;
        if (HREADY) begin
          state_d  = StData;
          htrans_d = HTRANS_IDLE;
        end
      end
      StData: begin
        if (HREADY) begin
          state_d = StDone;
          busy_d  = 1'b0;
          if (!hwrite_q) begin
            rd_vld_d  = 1'b1;
`ifdef AHB_BRIDGE_ERR_EN
            rd_data_d = HRESP ? 32'h0 : rsp_data;
`else
            rd_data_d = rsp_data;
`endif
          end
`ifdef AHB_BRIDGE_ERR_EN
          err_d = HRESP;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      haddr_q   <= 32'h0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hsize_q   <= HSIZE_BYTE;
      hwdata_q  <= 32'h0;
      rd_data_q <= 32'h0;
      rd_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AHB_BRIDGE_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hsize_q   <= hsize_d;
      hwdata_q  <= hwdata_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      busy_q    <= busy_d;
`ifdef AHB_BRIDGE_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = HBURST_SINGLE;
  assign HPROT       = HPROT_DEFAULT;
  assign HWDATA      = hwdata_q;
  assign ahb_rd_data = rd_data_q;
  assign ahb_rd_vld  = rd_vld_q;
  assign ahb_busy    = busy_q;

endmodule

// File: tb/tb_ahb_master_bridge.sv
// tb_ahb_master_bridge: directed self-checking bench for ahb_master_bridge.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ahb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ahb_en;
  logic        ahb_wr_en;
  logic [31:0] ahb_addr;
  logic [31:0] ahb_wr_data;
  logic [1:0]  ahb_data_size;
  logic [31:0] ahb_rd_data;
  logic        ahb_rd_vld;
  logic        ahb_busy;
`ifdef AHB_BRIDGE_ERR_EN
  logic        ahb_err;
`endif
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_master_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .ahb_en        (ahb_en),
    .ahb_wr_en     (ahb_wr_en),
    .ahb_addr      (ahb_addr),
    .ahb_wr_data   (ahb_wr_data),
    .ahb_data_size (ahb_data_size),
    .ahb_rd_data   (ahb_rd_data),
    .ahb_rd_vld    (ahb_rd_vld),
    .ahb_busy      (ahb_busy),
`ifdef AHB_BRIDGE_ERR_EN
    .ahb_err       (ahb_err),
`endif
    .HADDR         (HADDR),
    .HTRANS        (HTRANS),
    .HWRITE        (HWRITE),
    .HSIZE         (HSIZE),
    .HBURST        (HBURST),
    .HPROT         (HPROT),
    .HWDATA        (HWDATA),
    .HRDATA        (HRDATA),
    .HREADY        (HREADY),
    .HRESP         (HRESP)
  );

  // Presents a request for one cycle, then scrambles the request fields so any
  // post-acceptance sampling shows up. Returns in cycle N+1 (ADDR).
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size);
    @(negedge clk);
    ahb_en = 1'b1; ahb_wr_en = wr; ahb_addr = addr; ahb_wr_data = data; ahb_data_size = size;
    @(negedge clk);
    ahb_en = 1'b0; ahb_wr_en = ~wr; ahb_addr = 32'hFFFF_FFFF; ahb_wr_data = 32'hFFFF_FFFF;
    ahb_data_size = 2'b11;
  endtask

  task automatic test_reset();
    rst = 1'b1; ahb_en = 1'b0; ahb_wr_en = 1'b0; ahb_addr = '0; ahb_wr_data = '0;
    ahb_data_size = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans got %h exp 0", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr got %h exp 0", HADDR); end
    checks++; if ({HWRITE, HSIZE} !== 4'h0) begin errors++;
      $display("FAIL rst_hwrite_hsize got %b%b exp 0000", HWRITE, HSIZE); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata got %h exp 0", HWDATA); end
    checks++; if ({ahb_rd_data, ahb_rd_vld, ahb_busy} !== 34'h0) begin errors++;
      $display("FAIL rst_core got %h %b %b exp 0 0 0", ahb_rd_data, ahb_rd_vld, ahb_busy); end
    checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin errors++;
      $display("FAIL rst_const got %b %b exp 000 0011", HBURST, HPROT); end
`ifdef AHB_BRIDGE_ERR_EN
    checks++; if (ahb_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", ahb_err); end
`endif
  endtask

  task automatic test_word_read();
    HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
    issue(1'b0, 32'h2000_0010, 32'h0, 2'b10);
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h2000_0010) begin errors++;
      $display("FAIL wr_addr_phase got %h %h exp 2 20000010", HTRANS, HADDR); end
    checks++; if (HSIZE !== 3'b010 || HWRITE !== 1'b0 || ahb_busy !== 1'b1) begin errors++;
      $display("FAIL wr_ctrl got %b %b %b exp 010 0 1", HSIZE, HWRITE, ahb_busy); end
    @(negedge clk);
    checks++; if (HTRANS !== 2'b00 || ahb_busy !== 1'b1 || ahb_rd_vld !== 1'b0) begin errors++;
      $display("FAIL wr_data_phase got %h %b %b exp 0 1 0", HTRANS, ahb_busy, ahb_rd_vld); end
    @(negedge clk);
    checks++; if (ahb_rd_vld !== 1'b1 || ahb_rd_data !== 32'hDEAD_BEEF || ahb_busy !== 1'b0) begin
      errors++; $display("FAIL wr_done got %b %h %b exp 1 deadbeef 0",
                         ahb_rd_vld, ahb_rd_data, ahb_busy); end
    @(negedge clk);
    checks++; if (ahb_rd_vld !== 1'b0) begin errors++;
      $display("FAIL wr_vld_pulse got %b exp 0", ahb_rd_vld); end
  endtask

  task automatic test_byte_write();
    HREADY = 1'b1;
    issue(1'b1, 32'h2000_0003, 32'h1234_56A5, 2'b00);
    checks++; if (HADDR !== 32'h2000_0003 || HSIZE !== 3'b000 || HWRITE !== 1'b1) begin errors++;
      $display("FAIL bw_addr got %h %b %b exp 20000003 000 1", HADDR, HSIZE, HWRITE); end
    @(negedge clk);
    checks++; if (HWDATA !== 32'hA5A5_A5A5) begin errors++;
      $display("FAIL bw_hwdata got %h exp a5a5a5a5", HWDATA); end
    @(negedge clk);
    checks++; if (ahb_rd_vld !== 1'b0 || ahb_busy !== 1'b0) begin errors++;
      $display("FAIL bw_done got %b %b exp 0 0", ahb_rd_vld, ahb_busy); end
    // Halfword write from an odd address: aligned down, data duplicated.
    issue(1'b1, 32'h2000_0007, 32'hFFFF_BEEF, 2'b01);
    checks++; if (HADDR !== 32'h2000_0006 || HSIZE !== 3'b001) begin errors++;
      $display("FAIL hw_addr got %h %b exp 20000006 001", HADDR, HSIZE); end
    @(negedge clk);
    checks++; if (HWDATA !== 32'hBEEF_BEEF) begin errors++;
      $display("FAIL hw_hwdata got %h exp beefbeef", HWDATA); end
    @(negedge clk);
  endtask

  task automatic test_subword_read();
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    issue(1'b0, 32'h2000_0006, 32'h0, 2'b01);
    repeat (2) @(negedge clk);
    checks++; if (ahb_rd_vld !== 1'b1 || ahb_rd_data !== 32'h0000_1234) begin errors++;
      $display("FAIL hr_data got %b %h exp 1 00001234", ahb_rd_vld, ahb_rd_data); end
    issue(1'b0, 32'h2000_0001, 32'h0, 2'b00);
    repeat (2) @(negedge clk);
    checks++; if (ahb_rd_vld !== 1'b1 || ahb_rd_data !== 32'h0000_0056) begin errors++;
      $display("FAIL br_data got %b %h exp 1 00000056", ahb_rd_vld, ahb_rd_data); end
    // Size 11 behaves as a word access.
    issue(1'b0, 32'h2000_0013, 32'h0, 2'b11);
    checks++; if (HADDR !== 32'h2000_0010 || HSIZE !== 3'b010) begin errors++;
      $display("FAIL s3_addr got %h %b exp 20000010 010", HADDR, HSIZE); end
    repeat (2) @(negedge clk);
    checks++; if (ahb_rd_data !== 32'h1234_5678) begin errors++;
      $display("FAIL s3_data got %h exp 12345678", ahb_rd_data); end
  endtask

  task automatic test_wait_states();
    HRDATA = 32'h0BAD_F00D; HREADY = 1'b0;
    issue(1'b0, 32'h3000_0040, 32'h0, 2'b10);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc <= 3) begin
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h3000_0040 || ahb_busy !== 1'b1) begin
          errors++; $display("FAIL ws_addr_hold cyc %0d got %h %h %b exp 2 30000040 1",
                             cyc, HTRANS, HADDR, ahb_busy); end
      end else if (cyc <= 7) begin
        checks++; if (HTRANS !== 2'b00 || ahb_busy !== 1'b1 || ahb_rd_vld !== 1'b0) begin
          errors++; $display("FAIL ws_data_wait cyc %0d got %h %b %b exp 0 1 0",
                             cyc, HTRANS, ahb_busy, ahb_rd_vld); end
      end else begin
        checks++; if (ahb_rd_vld !== 1'b1 || ahb_rd_data !== 32'h0BAD_F00D) begin errors++;
          $display("FAIL ws_done got %b %h exp 1 0badf00d", ahb_rd_vld, ahb_rd_data); end
      end
      HREADY = (cyc == 3 || cyc == 7);
      @(negedge clk);
    end
    HREADY = 1'b1;
  endtask

  task automatic test_error();
    HREADY = 1'b1; HRESP = 1'b0;
    issue(1'b1, 32'h4000_0000, 32'h5555_AAAA, 2'b10);
    @(negedge clk);
    HRESP = 1'b1; HREADY = 1'b0;
    @(negedge clk);
    checks++; if (ahb_busy !== 1'b1) begin errors++;
      $display("FAIL err_wait got busy %b exp 1", ahb_busy); end
    HREADY = 1'b1;
    @(negedge clk);
    HRESP = 1'b0;
    checks++; if (ahb_busy !== 1'b0 || ahb_rd_vld !== 1'b0) begin errors++;
      $display("FAIL err_wr_done got %b %b exp 0 0", ahb_busy, ahb_rd_vld); end
`ifdef AHB_BRIDGE_ERR_EN
    checks++; if (ahb_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", ahb_err); end
`endif
    @(negedge clk);
`ifdef AHB_BRIDGE_ERR_EN
    checks++; if (ahb_err !== 1'b0) begin errors++; $display("FAIL err_once got %b exp 0", ahb_err); end
`endif
    // Read completing with ERROR.
    HRDATA = 32'hCAFE_F00D;
    issue(1'b0, 32'h4000_0004, 32'h0, 2'b10);
    HRESP = 1'b1;
    repeat (2) @(negedge clk);
    HRESP = 1'b0;
`ifdef AHB_BRIDGE_ERR_EN
    checks++; if (ahb_rd_vld !== 1'b1 || ahb_rd_data !== 32'h0 || ahb_err !== 1'b1) begin errors++;
      $display("FAIL err_rd got %b %h %b exp 1 0 1", ahb_rd_vld, ahb_rd_data, ahb_err); end
`else
    checks++; if (ahb_rd_vld !== 1'b1 || ahb_rd_data !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL err_rd got %b %h exp 1 cafef00d", ahb_rd_vld, ahb_rd_data); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    HREADY = 1'b1; HRDATA = 32'h7777_7777;
    issue(1'b0, 32'h5000_0008, 32'h0, 2'b10);
    @(negedge clk);
    rst = 1'b1; HREADY = 1'b0;
    @(negedge clk);
    rst = 1'b0; HREADY = 1'b1;
    checks++; if (HTRANS !== 2'b00 || ahb_busy !== 1'b0 || ahb_rd_vld !== 1'b0) begin errors++;
      $display("FAIL rm_abort got %h %b %b exp 0 0 0", HTRANS, ahb_busy, ahb_rd_vld); end
    checks++; if (HADDR !== 32'h0 || ahb_rd_data !== 32'h0) begin errors++;
      $display("FAIL rm_values got %h %h exp 0 0", HADDR, ahb_rd_data); end
    @(negedge clk);
    checks++; if (ahb_rd_vld !== 1'b0) begin errors++;
      $display("FAIL rm_no_vld got %b exp 0", ahb_rd_vld); end
  endtask

  // Second request presented in DONE of the first: 3-cycle spacing.
  task automatic test_back_to_back();
    HREADY = 1'b1; HRDATA = 32'h1111_2222;
    issue(1'b0, 32'h6000_0000, 32'h0, 2'b10);
    @(negedge clk);
    @(negedge clk);
    checks++; if (ahb_rd_vld !== 1'b1 || ahb_rd_data !== 32'h1111_2222) begin errors++;
      $display("FAIL bb_first got %b %h exp 1 11112222", ahb_rd_vld, ahb_rd_data); end
    ahb_en = 1'b1; ahb_wr_en = 1'b0; ahb_addr = 32'h6000_0020; ahb_data_size = 2'b10;
    @(negedge clk);
    ahb_en = 1'b0; HRDATA = 32'h3333_4444;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h6000_0020 || ahb_busy !== 1'b1) begin errors++;
      $display("FAIL bb_accept got %h %h %b exp 2 60000020 1", HTRANS, HADDR, ahb_busy); end
    repeat (2) @(negedge clk);
    checks++; if (ahb_rd_vld !== 1'b1 || ahb_rd_data !== 32'h3333_4444) begin errors++;
      $display("FAIL bb_second got %b %h exp 1 33334444", ahb_rd_vld, ahb_rd_data); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_subword_read();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
